timer_device: RTL and testbench



---
 rtl/timer_device_pkg.sv | 32 +++
 rtl/timer_device.sv | 127 ++++++++++++
 tb/tb_timer_device.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// FSM encodings, mode codes, CTRL bit positions and the bridge address windows.
package timer_device_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Bridge decode windows, inclusive on both ends.
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER0_LAST = 32'h0000_7F0B;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;
  localparam logic [31:0] TIMER1_LAST = 32'h0000_7F1B;

endpackage

// File: rtl/timer_device.sv
// Countdown timer with one-shot and auto-reload modes, a masked level interrupt
// and a combinational register read port for the system bridge.
module timer_device
  import timer_device_pkg::*;
#(
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [1:0]        sel;
  logic              unused_addr;
  logic              ctrl_im;
  logic [1:0]        ctrl_mode;
  logic              ctrl_en;
  logic [DATA_W-1:0] preset;
  logic [DATA_W-1:0] count;
  logic              flag;
  state_t            state;
  state_t            state_nxt;
  logic              ctrl_wr;
  logic              preset_wr;
  logic              do_load;
  logic              do_count;
  logic              expire;
  logic              int_oneshot;
  logic              int_periodic;

  // Count stops at zero instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] v);
    return (v > DATA_W'(1)) ? v - DATA_W'(1) : '0;
  endfunction

  assign sel         = addr[ADDR_LSB+1:ADDR_LSB];
  assign unused_addr = ^addr;
  assign ctrl_wr     = we && (sel == REG_CTRL);
  assign preset_wr   = we && (sel == REG_PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ctrl_en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CNT;
      ST_CNT: begin
        if (!ctrl_en)                 state_nxt = ST_IDLE;
        else if (count <= DATA_W'(1)) state_nxt = ST_INT;
      end
      ST_INT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    do_load      = 1'b0;
    do_count     = 1'b0;
    expire       = 1'b0;
    int_oneshot  = 1'b0;
    int_periodic = 1'b0;
    case (state)
      ST_LOAD: do_load = 1'b1;
      ST_CNT: begin
        if (ctrl_en) begin
          do_count = 1'b1;
          expire   = (count <= DATA_W'(1));
        end
      end
      ST_INT: begin
        if (ctrl_mode == MODE_PERIODIC) int_periodic = 1'b1;
        else                            int_oneshot  = 1'b1;
      end
      default: ;
    endcase
  end

  // Software writes win over FSM updates of EN and the flag in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_im   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_en   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      flag      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_im   <= din[CTRL_IM_BIT];
        ctrl_mode <= din[CTRL_MODE_MSB:CTRL_MODE_LSB];
        ctrl_en   <= din[CTRL_EN_BIT];
      end else if (int_oneshot) begin
        ctrl_en   <= 1'b0;
      end

      if (preset_wr) preset <= din;

      if (do_load)       count <= preset;
      else if (do_count) count <= sat_dec(count);

      if (ctrl_wr || preset_wr) flag <= 1'b0;
      else if (expire)          flag <= 1'b1;
      else if (int_periodic)    flag <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      REG_CTRL:   dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      REG_PRESET: dout = preset;
      REG_COUNT:  dout = count;
      default:    dout = '0;
    endcase
  end

  assign irq = ctrl_im & flag;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios plus randomized
// enable sequences compared against a closed-form timeline model.
module tb_timer_device;
  import timer_device_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_device #(.ADDR_LSB(2)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected COUNT/flag/EN after the k-th edge following the enabling CTRL
  // write (k=0 is that write's edge), starting from a freshly reset timer.
  function automatic void predict(input int k, input int p, input int mode,
                                  output logic [31:0] cnt, output logic flg,
                                  output logic en);
    int l;
    int j;
    l = (p < 1) ? 1 : p;
    cnt = 0; flg = 0; en = 1;
    if (k <= 1) begin
      cnt = 0;
    end else if (mode != int'(MODE_PERIODIC)) begin
      if (k < 2 + l)       cnt = p - (k - 2);
      else if (k == 2 + l) flg = 1;
      else begin flg = 1; en = 0; end
    end else begin
      j = (k - 1) % (l + 3);
      if (j >= 1 && j <= l) cnt = p - (j - 1);
      else if (j == l + 1)  flg = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [31:0] v);
    logic [31:0] rnd;
    rnd  = $urandom();
    addr = {rnd[31:4], r, rnd[1:0]};
    #1;
    v = dout;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] rnd;
    rnd  = $urandom();
    addr = {rnd[31:4], r, 2'b00};
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = '0;
  endtask

  task automatic run_trial(input int p, input int mode, input logic im,
                           input int kmax, input string tag);
    logic [31:0] v;
    logic [31:0] ecnt;
    logic        eflg;
    logic        een;
    logic [1:0]  m;
    m = mode[1:0];
    do_reset();
    bus_write(REG_PRESET, p);
    bus_write(REG_CTRL, {28'd0, im, m, 1'b1});
    read_reg(REG_PRESET, v);
    checks++;
    if (v !== p) begin
      errors++;
      $display("FAIL %s preset got %0d want %0d", tag, v, p);
    end
    for (int k = 0; k <= kmax; k++) begin
      predict(k, p, mode, ecnt, eflg, een);
      read_reg(REG_COUNT, v);
      checks++;
      if (v !== ecnt) begin
        errors++;
        $display("FAIL %s count k=%0d got %0d want %0d", tag, k, v, ecnt);
      end
      read_reg(REG_CTRL, v);
      checks++;
      if (v !== {28'd0, im, m, een}) begin
        errors++;
        $display("FAIL %s ctrl k=%0d got %h want %h", tag, k, v, {28'd0, im, m, een});
      end
      checks++;
      if (irq !== (im & eflg)) begin
        errors++;
        $display("FAIL %s irq k=%0d got %b want %b", tag, k, irq, im & eflg);
      end
      if (k < kmax) tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    #2;
    for (int r = 0; r < 4; r++) begin
      addr = r * 4;
      #1;
      checks++;
      if (dout !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr=%h got %h want 0", addr, dout);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b want 0", irq);
    end
    reset = 1'b0;
    tick();
    bus_write(REG_COUNT, 32'hFFFF_FFFF);
    read_reg(REG_COUNT, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL count_ro got %h want 0", v);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd3, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL reserved got %h want 0", v);
    end
    read_reg(REG_CTRL, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL ctrl_untouched got %h want 0", v);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    run_trial(3, 0, 1'b1, 9, "oneshot");
    bus_write(REG_CTRL, 32'h8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_ctrl_clear irq got %b want 0", irq);
    end
    read_reg(REG_CTRL, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl_after got %h want 8", v);
    end
    run_trial(0, 0, 1'b1, 5, "oneshot_p0");
    bus_write(REG_PRESET, 32'd7);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL preset_clear irq got %b want 0", irq);
    end
  endtask

  task automatic test_periodic();
    run_trial(2, 1, 1'b1, 16, "periodic");
  endtask

  task automatic test_mask_off();
    logic [31:0] v;
    run_trial(1, 0, 1'b0, 7, "mask_off");
    bus_write(REG_CTRL, 32'h8);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_off_unmask irq got %b want 0", irq);
    end
    read_reg(REG_CTRL, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("FAIL mask_off_ctrl got %h want 8", v);
    end
  endtask

  task automatic test_stop_mid();
    logic [31:0] v;
    bit found;
    do_reset();
    bus_write(REG_PRESET, 32'd10);
    bus_write(REG_CTRL, 32'h1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      read_reg(REG_COUNT, v);
      if (v == 32'd6) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stop_wait6 got %0d want 6 within 40 cycles", v);
    end
    bus_write(REG_CTRL, 32'h0);
    for (int i = 0; i < 4; i++) begin
      read_reg(REG_COUNT, v);
      checks++;
      if (v !== 32'd5) begin
        errors++;
        $display("FAIL stop_hold i=%0d got %0d want 5", i, v);
      end
      tick();
    end
    bus_write(REG_PRESET, 32'd4);
    read_reg(REG_COUNT, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("FAIL preset_no_effect got %0d want 5", v);
    end
    bus_write(REG_CTRL, 32'h1);
    tick();
    read_reg(REG_COUNT, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("FAIL reload_e1 got %0d want 5", v);
    end
    tick();
    read_reg(REG_COUNT, v);
    checks++;
    if (v !== 32'd4) begin
      errors++;
      $display("FAIL reload_e2 got %0d want 4", v);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    do_reset();
    bus_write(REG_PRESET, 32'd2);
    bus_write(REG_CTRL, 32'h9);
    tick();
    tick();
    tick();
    read_reg(REG_COUNT, v);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL simul_pre got %0d want 1", v);
    end
    bus_write(REG_CTRL, 32'h8);
    for (int i = 0; i < 5; i++) begin
      read_reg(REG_COUNT, v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL simul_count i=%0d got %0d want 0", i, v);
      end
      read_reg(REG_CTRL, v);
      checks++;
      if (v !== 32'h8) begin
        errors++;
        $display("FAIL simul_ctrl i=%0d got %h want 8", i, v);
      end
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL simul_irq i=%0d got %b want 0", i, irq);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    do_reset();
    bus_write(REG_PRESET, 32'd3);
    bus_write(REG_CTRL, 32'h9);
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      read_reg(r[1:0], v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL areset_mid reg=%0d got %h want 0", r, v);
      end
    end
    reset = 1'b0;
    tick();
    bus_write(REG_PRESET, 32'd3);
    bus_write(REG_CTRL, 32'h9);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre irq got %b want 1", irq);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL areset_irq got %b want 0", irq);
    end
    read_reg(REG_CTRL, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL areset_ctrl got %h want 0", v);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int p;
    int mode;
    int l;
    logic im;
    for (int t = 0; t < 20; t++) begin
      p    = $urandom_range(0, 12);
      mode = $urandom_range(0, 3);
      im   = 1'($urandom_range(0, 1));
      l    = (p < 1) ? 1 : p;
      run_trial(p, mode, im, 2 * (l + 3) + 3, "random");
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_mask_off();
    test_stop_mid();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
